// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake and registered N/V/Z flags.
//
// Stage 1 captures {In1, In2, ALUOp} on accept. Stage 2 computes the result and registers it
// into ALUOut together with the flag update. Backpressure comes from out_ready. Flush drops
// both stages without touching FLAG.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous drop of all in-flight ops (priority over accept)
//   in_valid   operands/op valid
//   in_ready   stage 1 can accept
//   In1, In2   operands; shift amount is In2[$clog2(WIDTH)-1:0]
//   ALUOp      0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB
//   out_valid  ALUOut valid
//   out_ready  consumer accepts ALUOut
//   ALUOut     registered result
//   FLAG       registered flags {Z, V, N}

module alu_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter bit          SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [2:0]       ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUOut,
   output logic [2:0]       FLAG
);

   localparam int unsigned ShW    = $clog2(WIDTH);
   localparam int unsigned NBytes = WIDTH / 8;
   localparam int unsigned NLanes = WIDTH / 4;
   localparam int unsigned Msb    = WIDTH - 1;

   localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      OpAdd    = 3'd0,
      OpSub    = 3'd1,
      OpXor    = 3'd2,
      OpRed    = 3'd3,
      OpSll    = 3'd4,
      OpSra    = 3'd5,
      OpRor    = 3'd6,
      OpPaddsb = 3'd7
   } op_e;

   // Stage 1 registers
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;
   op_e              s1_op_q;

   // Stage 2 / output registers
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] alu_out_q, alu_out_d;
   logic [2:0]       flag_q, flag_d;

   logic adv2, accept, load2;

   // Handshake
   assign adv2     = ~out_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | adv2;
   assign accept   = in_valid & in_ready & ~flush;
   assign load2    = s1_valid_q & adv2 & ~flush;

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (in_ready) begin
         // Either S1 was empty or it drains into S2 this edge
         s1_valid_d = in_valid;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (adv2) begin
         out_valid_d = s1_valid_q;
      end
   end

   // Execute
   logic [ShW-1:0]     shamt;
   logic [WIDTH-1:0]   sum, diff, red_acc, paddsb;
   logic [2*WIDTH-1:0] rot2;
   logic [4:0]         lane_sum;
   logic               add_ovf, sub_ovf;

   assign shamt   = s1_b_q[ShW-1:0];
   assign sum     = s1_a_q + s1_b_q;
   assign diff    = s1_a_q - s1_b_q;
   assign add_ovf = (s1_a_q[Msb] == s1_b_q[Msb]) && (sum[Msb] != s1_a_q[Msb]);
   assign sub_ovf = (s1_a_q[Msb] != s1_b_q[Msb]) && (diff[Msb] != s1_a_q[Msb]);
   // Doubled operand makes rotate a plain shift; shamt=0 yields In1 unchanged
   assign rot2    = {s1_a_q, s1_a_q} >> shamt;

   // Sum of all signed bytes of both operands, accumulated modulo 2^WIDTH
   always_comb begin
      red_acc = '0;
      for (int i = 0; i < NBytes; i++) begin
         red_acc = red_acc + {{(WIDTH-8){s1_a_q[8*i+7]}}, s1_a_q[8*i +: 8]}
                           + {{(WIDTH-8){s1_b_q[8*i+7]}}, s1_b_q[8*i +: 8]};
      end
   end

   // Independent saturating 4-bit lanes; overflow when the 5-bit sum's top two bits differ
   always_comb begin
      paddsb   = '0;
      lane_sum = '0;
      for (int i = 0; i < NLanes; i++) begin
         lane_sum = {s1_a_q[4*i+3], s1_a_q[4*i +: 4]} + {s1_b_q[4*i+3], s1_b_q[4*i +: 4]};
         if (lane_sum[4] != lane_sum[3]) begin
            paddsb[4*i +: 4] = lane_sum[4] ? 4'b1000 : 4'b0111;
         end else begin
            paddsb[4*i +: 4] = lane_sum[3:0];
         end
      end
   end

   always_comb begin
      alu_out_d = alu_out_q;
      flag_d    = flag_q;
      if (load2) begin
         unique case (s1_op_q)
            OpAdd: begin
               if (SAT && add_ovf) alu_out_d = s1_a_q[Msb] ? SatMin : SatMax;
               else                alu_out_d = sum;
               flag_d = {(alu_out_d == '0), add_ovf, alu_out_d[Msb]};
            end
            OpSub: begin
               if (SAT && sub_ovf) alu_out_d = s1_a_q[Msb] ? SatMin : SatMax;
               else                alu_out_d = diff;
               flag_d = {(alu_out_d == '0), sub_ovf, alu_out_d[Msb]};
            end
            OpXor: begin
               alu_out_d = s1_a_q ^ s1_b_q;
               flag_d[2] = (alu_out_d == '0);
            end
            OpRed: alu_out_d = red_acc;
            OpSll: begin
               alu_out_d = s1_a_q << shamt;
               flag_d[2] = (alu_out_d == '0);
            end
            OpSra: begin
               alu_out_d = $unsigned($signed(s1_a_q) >>> shamt);
               flag_d[2] = (alu_out_d == '0);
            end
            OpRor: begin
               alu_out_d = rot2[WIDTH-1:0];
               flag_d[2] = (alu_out_d == '0);
            end
            OpPaddsb: alu_out_d = paddsb;
            default: alu_out_d = alu_out_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= OpAdd;
         out_valid_q <= 1'b0;
         alu_out_q   <= '0;
         flag_q      <= 3'b000;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         alu_out_q   <= alu_out_d;
         flag_q      <= flag_d;
         if (accept) begin
            s1_a_q  <= In1;
            s1_b_q  <= In2;
            s1_op_q <= op_e'(ALUOp);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign ALUOut    = alu_out_q;
   assign FLAG      = flag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16, SAT=1): directed vector table, stall, flush and
// reset sequences, then randomized traffic scored against an arithmetic reference model.

module tb_alu_pipe;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid;
   logic [W-1:0]  in1 = '0, in2 = '0, alu_out;
   logic [2:0]    alu_op = '0, flag;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(W), .SAT(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .In1       (in1),
      .In2       (in2),
      .ALUOp     (alu_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUOut    (alu_out),
      .FLAG      (flag)
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [2:0]   flg;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic [2:0]   flg;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic acc;
   int   n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the op definitions. Flags are {Z, V, N}.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [2:0] fin,
                                 output logic [W-1:0] res, output logic [2:0] fout);
      int sa, sbv, s, sh, p, q, ua, la, lb;
      longint x;
      logic v;
      logic signed [7:0] bt;
      sa   = $signed(a);
      sbv  = $signed(b);
      ua   = a;
      sh   = b[3:0];
      p    = 2 ** sh;
      fout = fin;
      res  = '0;
      case (op)
         3'd0, 3'd1: begin
            s = (op == 3'd0) ? sa + sbv : sa - sbv;
            v = (s > 32767) || (s < -32768);
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            res  = s[15:0];
            fout = {(res == 16'h0), v, res[15]};
         end
         3'd2: begin
            res     = a ^ b;
            fout[2] = (res == 16'h0);
         end
         3'd3: begin
            s = 0;
            for (int i = 0; i < 2; i++) begin
               bt = a[8*i +: 8]; s = s + int'(bt);
               bt = b[8*i +: 8]; s = s + int'(bt);
            end
            res = s[15:0];
         end
         3'd4: begin
            x       = longint'(ua) * p;
            res     = x[15:0];
            fout[2] = (res == 16'h0);
         end
         3'd5: begin
            q = sa / p;
            if (sa < 0 && (sa % p) != 0) q = q - 1;
            res     = q[15:0];
            fout[2] = (res == 16'h0);
         end
         3'd6: begin
            x       = longint'(ua / p) + longint'(ua % p) * (65536 / p);
            res     = x[15:0];
            fout[2] = (res == 16'h0);
         end
         default: begin
            for (int i = 0; i < 4; i++) begin
               la = (ua >> (4*i)) & 15; if (la > 7) la = la - 16;
               lb = (int'(b) >> (4*i)) & 15; if (lb > 7) lb = lb - 16;
               s = la + lb;
               if (s > 7) s = 7;
               else if (s < -8) s = -8;
               res[4*i +: 4] = s[3:0];
            end
         end
      endcase
   endfunction

   // One clock: drive at negedge, then score whatever handshakes happen at the next posedge.
   task automatic cycle(input logic iv, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy, input logic fl,
                        input logic [W-1:0] eres, input logic [2:0] eflg, output logic accd);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      alu_op    = op;
      in1       = a;
      in2       = b;
      out_ready = ordy;
      flush     = fl;
      #1;
      accd = in_valid && in_ready && !flush;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got ALUOut=%0h with nothing pending, expected none",
                     alu_out);
         end else begin
            e = sb.pop_front();
            chk("aluout", alu_out, e.res);
            chk("flag", flag, e.flg);
         end
      end
      if (fl) sb.delete();
      if (accd) sb.push_back('{eres, eflg});
   endtask

   task automatic idle(input logic ordy);
      logic d;
      cycle(1'b0, 3'd0, '0, '0, ordy, 1'b0, '0, 3'b000, d);
   endtask

   task automatic drain(input int max, output int cnt);
      cnt = 0;
      while (sb.size() > 0 && cnt < max) begin
         idle(1'b1);
         cnt++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d ops still pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   function automatic logic [W-1:0] pick();
      if ($urandom_range(0, 3) == 0) begin
         case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'hFFFF;
         endcase
      end
      return W'($urandom);
   endfunction

   vec_t tv[21];

   initial begin
      logic [2:0]   mflg, rop, f;
      logic [W-1:0] ra, rb, r;
      logic         riv, rrdy;

      // Sequential: each expected FLAG follows from the previous row's flags.
      tv[0]  = '{3'd0, 16'h0003, 16'h0004, 16'h0007, 3'b000};
      tv[1]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010};
      tv[2]  = '{3'd1, 16'h8000, 16'h0001, 16'h8000, 3'b011};
      tv[3]  = '{3'd2, 16'h00FF, 16'h00FF, 16'h0000, 3'b111};
      tv[4]  = '{3'd2, 16'h0001, 16'h0000, 16'h0001, 3'b011};
      tv[5]  = '{3'd3, 16'h1234, 16'hFF80, 16'hFFC5, 3'b011};
      tv[6]  = '{3'd7, 16'h7777, 16'h1111, 16'h7777, 3'b011};
      tv[7]  = '{3'd6, 16'h0001, 16'h0001, 16'h8000, 3'b011};
      tv[8]  = '{3'd5, 16'h8000, 16'h000F, 16'hFFFF, 3'b011};
      tv[9]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 3'b100};
      tv[10] = '{3'd4, 16'h8001, 16'h0001, 16'h0002, 3'b000};
      tv[11] = '{3'd4, 16'h8000, 16'h0001, 16'h0000, 3'b100};
      tv[12] = '{3'd6, 16'h1234, 16'h0000, 16'h1234, 3'b000};
      tv[13] = '{3'd0, 16'h8000, 16'hFFFF, 16'h8000, 3'b011};
      tv[14] = '{3'd7, 16'h8888, 16'h8888, 16'h8888, 3'b011};
      tv[15] = '{3'd3, 16'h7F7F, 16'h7F7F, 16'h01FC, 3'b011};
      tv[16] = '{3'd5, 16'h4000, 16'h0003, 16'h0800, 3'b011};
      tv[17] = '{3'd6, 16'h00F0, 16'h0014, 16'h000F, 3'b011};
      tv[18] = '{3'd2, 16'hA5A5, 16'h5A5A, 16'hFFFF, 3'b011};
      tv[19] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b100};
      tv[20] = '{3'd7, 16'h1234, 16'h0F0F, 16'h1133, 3'b100};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_aluout", alu_out, 16'h0000);
      chk("rst_flag", flag, 3'b000);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);

      // Directed vectors, one op at a time, with 2-cycle latency check
      for (int i = 0; i < 21; i++) begin
         cycle(1'b1, tv[i].op, tv[i].a, tv[i].b, 1'b1, 1'b0, tv[i].res, tv[i].flg, acc);
         chk("vec_accept", acc, 1'b1);
         drain(10, n);
         chk("vec_latency", n, 2);
      end

      // Stall: out_ready low while three ops arrive back to back
      cycle(1'b1, 3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 3'b010, acc);
      chk("stall_acc_a", acc, 1'b1);
      cycle(1'b1, 3'd2, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000, 3'b110, acc);
      chk("stall_acc_b", acc, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 3'd1, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'hFFFF, 3'b001, acc);
         chk("stall_in_ready_low", acc, 1'b0);
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_aluout_held", alu_out, 16'h7FFF);
         chk("stall_flag_held", flag, 3'b010);
      end
      cycle(1'b1, 3'd1, 16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 3'b001, acc);
      chk("stall_acc_c", acc, 1'b1);
      drain(10, n);
      repeat (3) idle(1'b1);
      chk("stall_no_dup", out_valid, 1'b0);

      // Flush with both stages full; FLAG must keep the S2 op's value
      cycle(1'b1, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 3'b000, acc);
      cycle(1'b1, 3'd2, 16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0000, 3'b100, acc);
      cycle(1'b1, 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h000A, 3'b000, acc);
      chk("flush_pre_valid", out_valid, 1'b1);
      chk("flush_pre_flag", flag, 3'b000);
      chk("flush_drops_input", acc, 1'b0);
      idle(1'b1);
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_flag_held", flag, 3'b000);
      chk("flush_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         idle(1'b1);
         chk("flush_stays_empty", out_valid, 1'b0);
      end

      // Asynchronous reset mid-stream
      cycle(1'b1, 3'd0, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF, 3'b010, acc);
      cycle(1'b1, 3'd1, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 3'b001, acc);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      chk("prerst_out_valid", out_valid, 1'b1);
      chk("prerst_flag", flag, 3'b010);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_aluout", alu_out, 16'h0000);
      chk("midrst_flag", flag, 3'b000);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         idle(1'b1);
         chk("postrst_empty", out_valid, 1'b0);
      end

      // Randomized traffic with random backpressure against the reference model
      mflg = 3'b000;
      for (int k = 0; k < 400; k++) begin
         riv  = ($urandom_range(0, 3) != 0);
         rrdy = ($urandom_range(0, 3) != 0);
         rop  = 3'($urandom_range(0, 7));
         ra   = pick();
         rb   = pick();
         model(rop, ra, rb, mflg, r, f);
         cycle(riv, rop, ra, rb, rrdy, 1'b0, r, f, acc);
         if (acc) mflg = f;
      end
      drain(20, n);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
